// File: rtl/ramp_chk_pkg.sv
// Shared types and ramp arithmetic for the 14-bit ramp checker.
package ramp_chk_pkg;

    typedef enum logic [0:0] {ACQUIRE, LOCKED} chk_state_t;

    localparam int RAMP_BITS = 12;

    typedef logic [RAMP_BITS-1:0] ramp_t;

    localparam ramp_t WRAP_MAX = '1;

    function automatic ramp_t next_ramp(input ramp_t last);
        return last + ramp_t'(1);
    endfunction

endpackage

// File: rtl/ramp_checker_14bit_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats a same-cycle increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         aclk,
    input  logic         resetn,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/ramp_checker_14bit.sv
// AXI-Stream sink checking a wrapping ramp beat by beat, with programmable
// TREADY back-pressure, lock tracking and saturating status counters.
module ramp_checker_14bit
    import ramp_chk_pkg::*;
#(
    parameter int DATA_W       = 14,
    parameter int WRAP_BIT     = RAMP_BITS,
    parameter int CNT_W        = 32,
    parameter int READY_PERIOD = 1,
    parameter int READY_HIGH   = 1,
    parameter int LOSS_THRESH  = 4
) (
    input  logic              aclk,
    input  logic              resetn,
    input  logic              extenable,
    input  logic              clear,
    input  logic              S00_AXIS_TVALID,
    input  logic [DATA_W-1:0] S00_AXIS_TDATA,
    output logic              S00_AXIS_TREADY,
    output logic              locked,
    output logic              error_pulse,
    output logic              error_sticky,
    output logic [CNT_W-1:0]  beat_count,
    output logic [15:0]       err_count,
    output logic [15:0]       wrap_count
);

    localparam int PCNT_W = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;
    localparam int RUN_W  = $clog2(LOSS_THRESH + 1);

    localparam logic [PCNT_W-1:0]   PCNT_LAST = PCNT_W'(READY_PERIOD - 1);
    localparam logic [PCNT_W:0]     HIGH_V    = (PCNT_W + 1)'(READY_HIGH);
    localparam logic [RUN_W-1:0]    THRESH_V  = RUN_W'(LOSS_THRESH);
    localparam logic [WRAP_BIT-1:0] PRE_MAX   = WRAP_BIT'(WRAP_MAX) - WRAP_BIT'(1);

    chk_state_t          state;
    logic [PCNT_W-1:0]   pcnt;
    logic [WRAP_BIT-1:0] last;
    logic [RUN_W-1:0]    run;

    logic [WRAP_BIT-1:0]        data_low;
    logic [DATA_W-WRAP_BIT-1:0] data_high;
    logic [WRAP_BIT-1:0]        exp_val;
    logic [RUN_W-1:0]           run_inc;
    logic accept, upper_zero, legal, locked_accept, bad, wrap_hit;

    // The generator may drop MAX while stalled, so MAX-1 followed by 0 is also a legal step.
    always_comb begin
        data_low      = S00_AXIS_TDATA[WRAP_BIT-1:0];
        data_high     = S00_AXIS_TDATA[DATA_W-1:WRAP_BIT];
        accept        = S00_AXIS_TVALID & S00_AXIS_TREADY & extenable;
        upper_zero    = (data_high == '0);
        exp_val       = WRAP_BIT'(next_ramp(RAMP_BITS'(last)));
        legal         = upper_zero && ((data_low == exp_val) ||
                        ((last == PRE_MAX) && (data_low == '0)));
        locked_accept = accept && (state == LOCKED);
        bad           = locked_accept && !legal;
        wrap_hit      = locked_accept && legal && (data_low == '0);
        run_inc       = run + RUN_W'(1);
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state           <= ACQUIRE;
            pcnt            <= '0;
            S00_AXIS_TREADY <= 1'b0;
            last            <= '0;
            run             <= '0;
            locked          <= 1'b0;
            error_pulse     <= 1'b0;
            error_sticky    <= 1'b0;
        end else begin
            S00_AXIS_TREADY <= extenable & ({1'b0, pcnt} < HIGH_V);
            if (!extenable || (pcnt == PCNT_LAST)) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + PCNT_W'(1);
            end
            error_pulse <= bad;

            if (!extenable) begin
                state  <= ACQUIRE;
                locked <= 1'b0;
                run    <= '0;
            end else if (accept) begin
                case (state)
                    ACQUIRE: begin
                        if (upper_zero) begin
                            last   <= data_low;
                            state  <= LOCKED;
                            locked <= 1'b1;
                            run    <= '0;
                        end
                    end
                    LOCKED: begin
                        last <= data_low;
                        if (legal) begin
                            run <= '0;
                        end else if (run_inc >= THRESH_V) begin
                            state  <= ACQUIRE;
                            locked <= 1'b0;
                            run    <= '0;
                        end else begin
                            run <= run_inc;
                        end
                    end
                    default: begin
                        state  <= ACQUIRE;
                        locked <= 1'b0;
                    end
                endcase
            end

            if (bad) begin
                error_sticky <= 1'b1;
            end
            if (clear) begin
                error_sticky <= 1'b0;
                run          <= '0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_beat_cnt (
        .aclk   (aclk),
        .resetn (resetn),
        .clear  (clear),
        .inc    (accept),
        .count  (beat_count)
    );

    sat_counter #(.W(16)) u_err_cnt (
        .aclk   (aclk),
        .resetn (resetn),
        .clear  (clear),
        .inc    (bad),
        .count  (err_count)
    );

    sat_counter #(.W(16)) u_wrap_cnt (
        .aclk   (aclk),
        .resetn (resetn),
        .clear  (clear),
        .inc    (wrap_hit),
        .count  (wrap_count)
    );

endmodule
